rsa_uart_ctrl: RTL and testbench

RSA_UART_CTRL -- requirements
Module: rsa_uart_ctrl

---
 rtl/rsa_uart_pkg.sv | 28 ++
 rtl/rsa_uart_ctrl_if.sv | 29 ++
 rtl/rsa_uart_ctrl_parallel_to_serial.sv | 48 ++++
 rtl/rsa_uart.sv | 115 +++++++++++
 tb/tb_rsa_uart_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/rsa_uart_pkg.sv
// Shared constants for the RSA UART controller.
//   Command opcodes, the NAK byte, FSM state encodings, operand target codes,
//   and a helper that recognises valid command bytes.
package rsa_uart_pkg;

  localparam logic [7:0] CMD_LOAD_A = 8'h01;
  localparam logic [7:0] CMD_LOAD_B = 8'h02;
  localparam logic [7:0] CMD_LOAD_M = 8'h03;
  localparam logic [7:0] CMD_START  = 8'h10;
  localparam logic [7:0] NAK_BYTE   = 8'hEE;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_SEND  = 3'd4;
  localparam logic [2:0] ST_NAK   = 3'd5;

  localparam logic [1:0] TGT_A = 2'd0;
  localparam logic [1:0] TGT_B = 2'd1;
  localparam logic [1:0] TGT_M = 2'd2;

  function automatic logic is_command(input logic [7:0] b);
    return (b == CMD_LOAD_A) || (b == CMD_LOAD_B) ||
           (b == CMD_LOAD_M) || (b == CMD_START);
  endfunction

endpackage

// File: rtl/rsa_uart_ctrl_if.sv
// Bus bundle between the RSA UART controller and its UART/core neighbours.
//   UART rx: rx_valid, rx_byte         UART tx: tx_valid, tx_byte, tx_ready
//   Core:    op_a, op_b, op_m, core_start, core_done, core_result
// master = controller side, slave = UART + RSA core side.
interface rsa_uart_ctrl_if #(
  parameter int N = 32
);
  logic         rx_valid;
  logic [7:0]   rx_byte;
  logic         tx_ready;
  logic         tx_valid;
  logic [7:0]   tx_byte;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] op_m;
  logic         core_start;
  logic         core_done;
  logic [N-1:0] core_result;

  modport master (
    input  rx_valid, rx_byte, tx_ready, core_done, core_result,
    output tx_valid, tx_byte, op_a, op_b, op_m, core_start
  );

  modport slave (
    output rx_valid, rx_byte, tx_ready, core_done, core_result,
    input  tx_valid, tx_byte, op_a, op_b, op_m, core_start
  );
endinterface

// File: rtl/rsa_uart_ctrl_parallel_to_serial.sv
// N-bit parallel load, MSB-first byte serialiser with valid/ready handshake.
//   load/load_data/load_last : start a burst; load_last = index of final byte
//   tx_ready/tx_valid/tx_byte: byte stream, tx_byte held while stalled
//   done                     : combinational, high on the final transfer
module parallel_to_serial #(
  parameter int N   = 32,
  parameter int BCW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [N-1:0]   load_data,
  input  logic [BCW-1:0] load_last,
  input  logic           tx_ready,
  output logic           tx_valid,
  output logic [7:0]     tx_byte,
  output logic           done
);
  logic [N-1:0]   shift;
  logic [BCW-1:0] cnt;
  logic [BCW-1:0] last;

  assign tx_byte = shift[N-1:N-8];
  assign done    = tx_valid && tx_ready && (cnt == last);

  always_ff @(posedge clk) begin
    if (reset) begin
      shift    <= '0;
      cnt      <= '0;
      last     <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shift    <= load_data;
      cnt      <= '0;
      last     <= load_last;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      // Zero fill means tx_byte reads 0 once the burst has drained.
      shift <= {shift[N-9:0], 8'h00};
      if (cnt == last) begin
        cnt      <= '0;
        tx_valid <= 1'b0;
      end else begin
        cnt <= cnt + BCW'(1);
      end
    end
  end
endmodule

// File: rtl/rsa_uart.sv
// RSA UART command controller.
//   iCE_CLK : clock, rising edge     reset : synchronous, active-high
//   bus     : UART rx/tx and RSA core signals (master modport)
//   busy    : FSM not idle           err   : sticky protocol error
// Commands: 01/02/03 load A/B/M with N/8 MSB-first bytes, 10 runs the core
// and returns the N-bit result MSB-first; anything else answers 0xEE.
module rsa_uart_ctrl
  import rsa_uart_pkg::*;
#(
  parameter int N   = 32,
  parameter int BCW = 3
) (
  input  logic              iCE_CLK,
  input  logic              reset,
  rsa_uart_ctrl_if.master   bus,
  output logic              busy,
  output logic              err
);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(N/8 - 1);

  logic [2:0]     state;
  logic [1:0]     target;
  logic [BCW-1:0] rx_cnt;
  logic [N-9:0]   rx_shift;

  logic           ser_load;
  logic [N-1:0]   ser_data;
  logic [BCW-1:0] ser_last;
  logic           ser_done;

  assign busy           = (state != ST_IDLE);
  assign bus.core_start = (state == ST_START);

  // The serialiser is loaded on the same edge that enters NAK or SEND,
  // so tx_valid rises together with the state change.
  always_comb begin
    ser_load = 1'b0;
    ser_data = '0;
    ser_last = '0;
    if (state == ST_IDLE && bus.rx_valid && !is_command(bus.rx_byte)) begin
      ser_load = 1'b1;
      ser_data = {NAK_BYTE, (N-8)'(0)};
    end else if (state == ST_WAIT && bus.core_done) begin
      ser_load = 1'b1;
      ser_data = bus.core_result;
      ser_last = LAST_BYTE;
    end
  end

  always_ff @(posedge iCE_CLK) begin
    if (reset) begin
      state    <= ST_IDLE;
      target   <= TGT_A;
      rx_cnt   <= '0;
      rx_shift <= '0;
      bus.op_a <= '0;
      bus.op_b <= '0;
      bus.op_m <= '0;
      err      <= 1'b0;
    end else begin
      if ((bus.rx_valid && (state == ST_START || state == ST_WAIT ||
                            state == ST_SEND  || state == ST_NAK)) ||
          (bus.core_done && state != ST_WAIT))
        err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (bus.rx_valid) begin
            rx_cnt <= '0;
            case (bus.rx_byte)
              CMD_LOAD_A: begin target <= TGT_A; state <= ST_LOAD; end
              CMD_LOAD_B: begin target <= TGT_B; state <= ST_LOAD; end
              CMD_LOAD_M: begin target <= TGT_M; state <= ST_LOAD; end
              CMD_START:  state <= ST_START;
              default:    state <= ST_NAK;
            endcase
          end
        end
        ST_LOAD: begin
          if (bus.rx_valid) begin
            if (rx_cnt == LAST_BYTE) begin
              case (target)
                TGT_A:   bus.op_a <= {rx_shift, bus.rx_byte};
                TGT_B:   bus.op_b <= {rx_shift, bus.rx_byte};
                default: bus.op_m <= {rx_shift, bus.rx_byte};
              endcase
              rx_cnt <= '0;
              state  <= ST_IDLE;
            end else begin
              rx_shift <= (N-8)'({rx_shift, bus.rx_byte});
              rx_cnt   <= rx_cnt + BCW'(1);
            end
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT:  if (bus.core_done) state <= ST_SEND;
        ST_SEND,
        ST_NAK:   if (ser_done) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  parallel_to_serial #(.N(N), .BCW(BCW)) u_tx (
    .clk       (iCE_CLK),
    .reset     (reset),
    .load      (ser_load),
    .load_data (ser_data),
    .load_last (ser_last),
    .tx_ready  (bus.tx_ready),
    .tx_valid  (bus.tx_valid),
    .tx_byte   (bus.tx_byte),
    .done      (ser_done)
  );
endmodule

// File: tb/tb_rsa_uart_ctrl.sv
// Directed self-checking bench for rsa_uart_ctrl at N=32.
module tb_rsa_uart_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic busy, err;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   xfers = 0;
  int   starts = 0;

  rsa_uart_ctrl_if #(.N(32)) bus ();

  rsa_uart_ctrl #(.N(32), .BCW(3)) dut (
    .iCE_CLK (clk),
    .reset   (reset),
    .bus     (bus.master),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.tx_valid && bus.tx_ready) xfers <= xfers + 1;
    if (bus.core_start) starts <= starts + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  logic [7:0] exp_b;
  logic [31:0] res;

  initial begin
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte = 8'h00;
    bus.tx_ready = 1'b0;
    bus.core_done = 1'b0;
    bus.core_result = '0;
    step(); step();
    reset = 1'b0;
    check("rst_op_a", bus.op_a, 32'h0);
    check("rst_op_b", bus.op_b, 32'h0);
    check("rst_op_m", bus.op_m, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_tx_byte", bus.tx_byte, 8'h00);
    check("rst_core_start", bus.core_start, 1'b0);

    // Load A
    send_rx(8'h01); send_rx(8'hAA);
    check("load_busy", busy, 1'b1);
    send_rx(8'hBB); send_rx(8'hCC); send_rx(8'hDD);
    check("load_a", bus.op_a, 32'hAABBCCDD);
    check("load_a_b", bus.op_b, 32'h0);
    check("load_a_m", bus.op_m, 32'h0);
    check("load_a_idle", busy, 1'b0);

    // Load M
    send_rx(8'h03); send_rx(8'h00); send_rx(8'h00); send_rx(8'h00); send_rx(8'h07);
    check("load_m", bus.op_m, 32'h00000007);
    check("load_m_a", bus.op_a, 32'hAABBCCDD);
    check("load_m_b", bus.op_b, 32'h0);

    // Unknown command -> NAK, held while tx_ready=0
    send_rx(8'h7F);
    check("nak_valid", bus.tx_valid, 1'b1);
    check("nak_byte", bus.tx_byte, 8'hEE);
    step();
    check("nak_hold", bus.tx_byte, 8'hEE);
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
    check("nak_done_valid", bus.tx_valid, 1'b0);
    check("nak_done_busy", busy, 1'b0);
    check("nak_xfers", xfers, 1);
    check("nak_op_a", bus.op_a, 32'hAABBCCDD);
    check("nak_err", err, 1'b0);

    // Start, core result, tx_ready toggling
    send_rx(8'h10);
    check("start_pulse", bus.core_start, 1'b1);
    step();
    check("start_low", bus.core_start, 1'b0);
    check("wait_busy", busy, 1'b1);
    step(); step(); step();
    bus.core_done = 1'b1;
    bus.core_result = 32'h12345678;
    step();
    bus.core_done = 1'b0;
    res = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      exp_b = res[31 - 8*i -: 8];
      check("send_valid", bus.tx_valid, 1'b1);
      check("send_byte", bus.tx_byte, exp_b);
      step();
      check("send_hold", bus.tx_byte, exp_b);
      bus.tx_ready = 1'b1;
      step();
      bus.tx_ready = 1'b0;
    end
    check("send_done_valid", bus.tx_valid, 1'b0);
    check("send_done_busy", busy, 1'b0);
    check("send_starts", starts, 1);
    check("send_xfers", xfers, 5);
    check("send_err", err, 1'b0);

    // rx during WAIT sets err, result still returned
    send_rx(8'h10);
    step();
    send_rx(8'h01);
    check("wait_rx_err", err, 1'b1);
    check("wait_rx_busy", busy, 1'b1);
    bus.core_done = 1'b1;
    bus.core_result = 32'hCAFEF00D;
    bus.tx_ready = 1'b1;
    step();
    bus.core_done = 1'b0;
    res = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      exp_b = res[31 - 8*i -: 8];
      check("err_send_byte", bus.tx_byte, exp_b);
      step();
    end
    check("err_send_valid", bus.tx_valid, 1'b0);
    check("err_send_busy", busy, 1'b0);
    check("err_sticky", err, 1'b1);
    check("err_op_a", bus.op_a, 32'hAABBCCDD);
    check("err_xfers", xfers, 9);

    // Reset mid-LOAD, then reload B
    send_rx(8'h02); send_rx(8'h11); send_rx(8'h22);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midload_err", err, 1'b0);
    check("midload_busy", busy, 1'b0);
    check("midload_op_a", bus.op_a, 32'h0);
    send_rx(8'h02); send_rx(8'h33); send_rx(8'h44); send_rx(8'h55); send_rx(8'h66);
    check("reload_b", bus.op_b, 32'h33445566);
    check("reload_a", bus.op_a, 32'h0);
    check("reload_m", bus.op_m, 32'h0);
    check("reload_err", err, 1'b0);

    // core_done in IDLE
    bus.core_done = 1'b1;
    bus.core_result = 32'hFFFFFFFF;
    step();
    bus.core_done = 1'b0;
    check("idle_done_err", err, 1'b1);
    check("idle_done_busy", busy, 1'b0);
    check("idle_done_tx", bus.tx_valid, 1'b0);
    step(); step();
    check("idle_done_xfers", xfers, 9);

    // Reset mid-SEND
    bus.tx_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    send_rx(8'h10);
    step();
    bus.core_done = 1'b1;
    bus.core_result = 32'h9ABCDEF0;
    step();
    bus.core_done = 1'b0;
    check("midsend_byte", bus.tx_byte, 8'h9A);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midsend_valid", bus.tx_valid, 1'b0);
    check("midsend_txbyte", bus.tx_byte, 8'h00);
    check("midsend_busy", busy, 1'b0);
    check("midsend_op_b", bus.op_b, 32'h0);

    // Reset priority over rx_valid and core_done
    reset = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_byte = 8'h01;
    bus.core_done = 1'b1;
    step();
    reset = 1'b0;
    bus.rx_valid = 1'b0;
    bus.core_done = 1'b0;
    check("prio_busy", busy, 1'b0);
    check("prio_err", err, 1'b0);
    check("prio_start", bus.core_start, 1'b0);
    check("prio_starts", starts, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
